// File: rtl/rally_ctrl.sv
// Rally/match sequencer: serve hold, touch counting, point award, winner.
// Optional SIDE_OUT_EN macro selects side-out scoring (default: rally scoring).
module rally_ctrl #(
  parameter logic [11:0] NET_X        = 12'd512,
  parameter int          MAX_TOUCH    = 3,
  parameter int          WIN_SCORE    = 15,
  parameter int          SERVE_FRAMES = 60,
  parameter int          POINT_FRAMES = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        gnd_col,
  input  logic        pl1_col,
  input  logic        pl2_col,
  input  logic [11:0] ball_posx,
  output logic        ball_hold,
  output logic        serve_pl2,
  output logic [4:0]  score1,
  output logic [4:0]  score2,
  output logic [1:0]  touch_cnt,
  output logic        ovr_touch,
  output logic [1:0]  winner,
  output logic        busy
);

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [1:0] TOUCH_MAX  = 2'(MAX_TOUCH);
  localparam logic [4:0] WIN        = 5'(WIN_SCORE);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  state_t      state_q, state_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        hold_q, hold_d;
  logic        srv_q, srv_d;
  logic [4:0]  s1_q, s1_d;
  logic [4:0]  s2_q, s2_d;
  logic [1:0]  tcnt_q, tcnt_d;
  logic        owner_q, owner_d;
  logic        ovr_q, ovr_d;
  logic [1:0]  win_q, win_d;
  logic        busy_q, busy_d;
  logic        gnd_prev_q, pl1_prev_q, pl2_prev_q;

  logic gnd_rise, pl1_rise, pl2_rise;
  logic award, to_p2, score_inc;

  assign gnd_rise = gnd_col & ~gnd_prev_q;
  assign pl1_rise = pl1_col & ~pl1_prev_q;
  assign pl2_rise = pl2_col & ~pl2_prev_q;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    hold_d    = hold_q;
    srv_d     = srv_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    tcnt_d    = tcnt_q;
    owner_d   = owner_q;
    ovr_d     = 1'b0;
    win_d     = win_q;
    busy_d    = busy_q;
    award     = 1'b0;
    to_p2     = 1'b0;
    score_inc = 1'b1;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_SERVE;
          fcnt_d  = 8'd0;
          hold_d  = 1'b1;
          busy_d  = 1'b1;
          srv_d   = 1'b0;
          s1_d    = 5'd0;
          s2_d    = 5'd0;
          win_d   = 2'b00;
          tcnt_d  = 2'd0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (fcnt_q == SERVE_LAST) begin
            state_d = S_PLAY;
            fcnt_d  = 8'd0;
            hold_d  = 1'b0;
            tcnt_d  = 2'd0;
            owner_d = 1'b0;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        // A ground hit pre-empts any touch (and any fault) in the same cycle.
        if (gnd_rise) begin
          award = 1'b1;
          to_p2 = (ball_posx < NET_X);
        end else if (pl1_rise ^ pl2_rise) begin
          if (pl2_rise == owner_q) begin
            if (tcnt_q == TOUCH_MAX) begin
              ovr_d = 1'b1;
              award = 1'b1;
              to_p2 = ~pl2_rise;
            end else begin
              tcnt_d = tcnt_q + 2'd1;
            end
          end else begin
            owner_d = pl2_rise;
            tcnt_d  = 2'd1;
          end
        end
`ifdef SIDE_OUT_EN
        score_inc = (to_p2 == srv_q);
`endif
        if (award) begin
          state_d = S_POINT;
          fcnt_d  = 8'd0;
          hold_d  = 1'b1;
          srv_d   = to_p2;
          if (score_inc) begin
            if (to_p2) s2_d = (s2_q == 5'd31) ? s2_q : s2_q + 5'd1;
            else       s1_d = (s1_q == 5'd31) ? s1_q : s1_q + 5'd1;
          end
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          if (fcnt_q == POINT_LAST) begin
            fcnt_d = 8'd0;
            if (s1_q >= WIN || s2_q >= WIN) begin
              state_d = S_OVER;
              busy_d  = 1'b0;
              win_d   = (s1_q >= WIN) ? 2'b01 : 2'b10;
            end else begin
              state_d = S_SERVE;
              tcnt_d  = 2'd0;
            end
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fcnt_q     <= 8'd0;
      hold_q     <= 1'b1;
      srv_q      <= 1'b0;
      s1_q       <= 5'd0;
      s2_q       <= 5'd0;
      tcnt_q     <= 2'd0;
      owner_q    <= 1'b0;
      ovr_q      <= 1'b0;
      win_q      <= 2'b00;
      busy_q     <= 1'b0;
      gnd_prev_q <= 1'b0;
      pl1_prev_q <= 1'b0;
      pl2_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      hold_q     <= hold_d;
      srv_q      <= srv_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      tcnt_q     <= tcnt_d;
      owner_q    <= owner_d;
      ovr_q      <= ovr_d;
      win_q      <= win_d;
      busy_q     <= busy_d;
      gnd_prev_q <= gnd_col;
      pl1_prev_q <= pl1_col;
      pl2_prev_q <= pl2_col;
    end
  end

  assign ball_hold = hold_q;
  assign serve_pl2 = srv_q;
  assign score1    = s1_q;
  assign score2    = s2_q;
  assign touch_cnt = tcnt_q;
  assign ovr_touch = ovr_q;
  assign winner    = win_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Bench for rally_ctrl: directed steps plus random rallies against an
// event-level scoring model (consecutive-touch runs, point awards, match end).
module tb_rally_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        frame_tick = 1'b0, start = 1'b0;
  logic        gnd_col = 1'b0, pl1_col = 1'b0, pl2_col = 1'b0;
  logic [11:0] ball_posx = 12'd0;
  logic        ball_hold, serve_pl2, ovr_touch, busy;
  logic [4:0]  score1, score2;
  logic [1:0]  touch_cnt, winner;

  int total = 0, bad = 0;
  int m_s1 = 0, m_s2 = 0, m_last = 0, m_run = 0, m_win = 0;
  bit m_srv = 1'b0;
  localparam int WIN = 15;

  rally_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .gnd_col(gnd_col), .pl1_col(pl1_col), .pl2_col(pl2_col), .ball_posx(ball_posx),
    .ball_hold(ball_hold), .serve_pl2(serve_pl2), .score1(score1), .score2(score2),
    .touch_cnt(touch_cnt), .ovr_touch(ovr_touch), .winner(winner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input bit hold, input bit bsy);
    chk({tag, "_hold"},   8'(ball_hold), 8'(hold));
    chk({tag, "_busy"},   8'(busy),      8'(bsy));
    chk({tag, "_serve"},  8'(serve_pl2), 8'(m_srv));
    chk({tag, "_score1"}, 8'(score1),    8'(m_s1));
    chk({tag, "_score2"}, 8'(score2),    8'(m_s2));
    chk({tag, "_winner"}, 8'(winner),    8'(m_win));
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_srv = 1'b0; m_win = 0; m_run = 0; m_last = 0;
  endtask

  // Point to player 2 when to_p2; server keeps the serve or the winner takes it.
  task automatic award(input bit to_p2);
    bit inc;
    inc = 1'b1;
`ifdef SIDE_OUT_EN
    inc = (to_p2 == m_srv);
`endif
    if (inc) begin
      if (to_p2) begin if (m_s2 < 31) m_s2++; end
      else       begin if (m_s1 < 31) m_s1++; end
    end
    m_srv = to_p2;
  endtask

  // p: 0 player 1, 1 player 2, 2 both at once (ignored).
  task automatic model_touch(input int p, output bit fault);
    fault = 1'b0;
    if (p != 2) begin
      if (m_run > 0 && m_last == p) begin
        if (m_run == 3) fault = 1'b1;
        else m_run++;
      end else begin
        m_last = p;
        m_run  = 1;
      end
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
  endtask

  task automatic serve_phase();
    repeat (59) tick();
    chk("serve59_hold", 8'(ball_hold), 8'd1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    m_run = 0;
    chk("release_hold", 8'(ball_hold), 8'd0);
    chk("play_busy",    8'(busy),      8'd1);
    chk("play_tcnt",    8'(touch_cnt), 8'd0);
  endtask

  task automatic point_phase();
    repeat (89) tick();
    chk("point89_hold", 8'(ball_hold), 8'd1);
    chk("point89_busy", 8'(busy),      8'd1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    if (m_s1 >= WIN || m_s2 >= WIN) begin
      m_win = (m_s1 >= WIN) ? 1 : 2;
      chk_state("over", 1'b1, 1'b0);
    end else begin
      chk_state("reserve", 1'b1, 1'b1);
      chk("reserve_tcnt", 8'(touch_cnt), 8'd0);
      serve_phase();
    end
  endtask

  task automatic touch(input int p, output bit ended);
    bit f;
    pl1_col = (p != 1); pl2_col = (p != 0);
    step();
    model_touch(p, f);
    chk("ovr_pulse", 8'(ovr_touch), 8'(f));
    chk("touch_cnt", 8'(touch_cnt), 8'(m_run));
    pl1_col = 1'b0; pl2_col = 1'b0;
    step();
    chk("ovr_clear", 8'(ovr_touch), 8'd0);
    ended = f;
    if (f) begin
      award(p == 0);
      chk_state("fault_point", 1'b1, 1'b1);
      point_phase();
    end
  endtask

  // Ground hit at x; optional simultaneous frame tick and player edge (p<0: none).
  task automatic ground(input logic [11:0] x, input bit with_tick, input int p);
    ball_posx  = x;
    gnd_col    = 1'b1;
    frame_tick = with_tick;
    if (p == 0 || p == 2) pl1_col = 1'b1;
    if (p == 1 || p == 2) pl2_col = 1'b1;
    step();
    gnd_col = 1'b0; frame_tick = 1'b0; pl1_col = 1'b0; pl2_col = 1'b0;
    award(x < 12'd512);
    chk("gnd_ovr", 8'(ovr_touch), 8'd0);
    chk_state("gnd_point", 1'b1, 1'b1);
    step();
    point_phase();
  endtask

  task automatic rally();
    bit ended;
    int r;
    ended = 1'b0;
    for (int i = 0; i < 40 && !ended; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       touch(0, ended);
      else if (r < 8)  touch(1, ended);
      else if (r == 8) touch(2, ended);
      else begin
        ground(12'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), -1);
        ended = 1'b1;
      end
    end
    if (!ended) ground(12'($urandom_range(0, 1023)), 1'b0, -1);
  endtask

  task automatic new_match();
    start = 1'b1; step(); start = 1'b0;
    model_reset();
    chk_state("start", 1'b1, 1'b1);
    chk("start_tcnt", 8'(touch_cnt), 8'd0);
    serve_phase();
  endtask

  initial begin
    bit e;
    int n;
    model_reset();
    #12;
    chk_state("reset", 1'b1, 1'b0);
    chk("reset_tcnt", 8'(touch_cnt), 8'd0);
    chk("reset_ovr",  8'(ovr_touch), 8'd0);
    rst = 1'b1;
    step(); step();
    chk_state("idle", 1'b1, 1'b0);

    new_match();
    ground(12'd300, 1'b1, -1);

    for (int i = 0; i < 4; i++) touch(0, e);

    touch(0, e); touch(1, e); touch(0, e); touch(2, e);
    touch(1, e); touch(1, e); touch(1, e);
    ground(12'd512, 1'b0, 1);

    start = 1'b1; step(); start = 1'b0;
    chk("start_ign_hold", 8'(ball_hold), 8'd0);
    chk("start_ign_tcnt", 8'(touch_cnt), 8'(m_run));
    chk_state("start_ign", 1'b0, 1'b1);
    touch(0, e);
    ground(12'd511, 1'b0, -1);

    n = 0;
    while (m_win == 0 && n < 60) begin
      ground(12'd700, 1'b0, -1);
      n++;
    end
    step();
    chk_state("over_hold", 1'b1, 1'b0);

    new_match();
    n = 0;
    while (m_win == 0 && n < 120) begin
      rally();
      n++;
    end

    new_match();
    touch(0, e); touch(0, e);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk_state("async_rst", 1'b1, 1'b0);
    chk("async_tcnt", 8'(touch_cnt), 8'd0);
    chk("async_ovr",  8'(ovr_touch), 8'd0);
    #2;
    rst = 1'b1;
    step(); step();
    chk_state("post_rst", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
